mult_wb_ctrl: RTL and testbench

Issue and writeback controller for the pipelined integer multiplier used by the RV32M execute path. It accepts MUL/MULH/MULHSU/MULHU requests with a valid/ready handshake and maps each to the multiplier's operand and sign inputs. It tracks in-flight operations in a fixed-latency tag pipeline and selects the low or high product word. Results are buffered in a credit-protected FIFO, so a writeback stall never drops a result from the non-stallable multiplier.

---
 rtl/mult_wb_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mult_wb_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_wb_ctrl.sv
// mult_wb_ctrl: issue/writeback controller for the pipelined RV32M multiplier.
//   Maps MUL/MULH/MULHSU/MULHU requests onto the multiplier's operand and sign
//   inputs. It tracks each in-flight op in a fixed-latency tag pipeline and
//   buffers the selected product word in a credit-protected result FIFO.
//   The credits keep the FIFO from overflowing while the multiplier cannot stall.
// Ports:
//   clock, reset_n (async, active low), flush
//   req_valid/req_ready/req_func/req_rs1/req_rs2/req_tag : request handshake
//   mult_start/mult_sign/mult_mcand/mult_mplier          : to multiplier
//   mult_product/mult_done                               : from multiplier
//   wb_valid/wb_ready/wb_data/wb_tag                     : result FIFO head
//   lat_err                                              : sticky latency mismatch
// Build option: define MULT_WB_LATCHK_EN to enable the mult_done latency check;
//   when it is undefined, lat_err is tied low.
module mult_wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGE  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_func,
  input  logic [XLEN-1:0]     req_rs1,
  input  logic [XLEN-1:0]     req_rs2,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                mult_start,
  output logic [1:0]          mult_sign,
  output logic [XLEN-1:0]     mult_mcand,
  output logic [XLEN-1:0]     mult_mplier,
  input  logic [2*XLEN-1:0]   mult_product,
  input  logic                mult_done,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [XLEN-1:0]     wb_data,
  output logic [TAG_W-1:0]    wb_tag,
  output logic                lat_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + NUM_STAGE + 1) + 1;

  typedef struct packed {
    logic             vld;
    logic             hi;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t [NUM_STAGE-1:0]              pipe_q, pipe_d;
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                  fifo_cnt_q, fifo_cnt_d, inflight_q, inflight_d;
  logic [FIFO_DEPTH-1:0][XLEN-1:0]   data_q, data_d;
  logic [FIFO_DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;

  logic             accept, hi_sel, fifo_wr, fifo_rd;
  ent_t             last;
  logic [XLEN-1:0]  wr_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    // sign[0] = rs1 (mcand) signed, sign[1] = rs2 (mplier) signed
    mult_sign = 2'b00;
    case (req_func)
      2'b01:   mult_sign = 2'b11;
      2'b10:   mult_sign = 2'b01;
      default: mult_sign = 2'b00;
    endcase
    hi_sel = (req_func != 2'b00);

    // Every accepted op owns a FIFO slot from issue until it is read out.
    req_ready   = !flush && ((fifo_cnt_q + inflight_q) < CNT_W'(FIFO_DEPTH));
    accept      = req_valid & req_ready;
    mult_start  = accept;
    mult_mcand  = req_rs1;
    mult_mplier = req_rs2;

    last     = pipe_q[NUM_STAGE-1];
    wb_valid = (fifo_cnt_q != '0);
    wb_data  = data_q[rd_ptr_q];
    wb_tag   = tag_q[rd_ptr_q];

    fifo_wr = last.vld & !flush;
    fifo_rd = wb_valid & wb_ready & !flush;
    wr_data = last.hi ? mult_product[2*XLEN-1:XLEN] : mult_product[XLEN-1:0];

    pipe_d[0] = '{vld: accept, hi: hi_sel, tag: req_tag};
    for (int i = 1; i < NUM_STAGE; i++) pipe_d[i] = pipe_q[i-1];
    if (flush) begin
      for (int i = 0; i < NUM_STAGE; i++) pipe_d[i].vld = 1'b0;
    end

    data_d = data_q;
    tag_d  = tag_q;
    if (fifo_wr) begin
      data_d[wr_ptr_q] = wr_data;
      tag_d[wr_ptr_q]  = last.tag;
    end

    wr_ptr_d   = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fifo_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(last.vld);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
      data_q     <= '0;
      tag_q      <= '0;
    end else begin
      pipe_q     <= pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
    end
  end

`ifdef MULT_WB_LATCHK_EN
  // Shadow of every start, never cleared by flush: the multiplier keeps
  // running through a flush, so its done pulses must still line up with this.
  logic [NUM_STAGE-1:0] issued_q, issued_d;
  logic                 lat_err_q, lat_err_d;

  always_comb begin
    issued_d[0] = mult_start;
    for (int i = 1; i < NUM_STAGE; i++) issued_d[i] = issued_q[i-1];
    lat_err_d = lat_err_q | (mult_done ^ issued_q[NUM_STAGE-1]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      lat_err_q <= 1'b0;
    end else begin
      issued_q  <= issued_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign lat_err = lat_err_q;
`else
  logic unused_done;
  assign unused_done = mult_done;
  assign lat_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_wb_ctrl.sv
module tb_mult_wb_ctrl;
  localparam int XLEN = 32, NUM_STAGE = 4, FIFO_DEPTH = 8, TAG_W = 5;

  logic clock, reset_n, flush, req_valid, req_ready, mult_start, mult_done;
  logic wb_valid, wb_ready, lat_err, inj;
  logic [1:0] req_func, mult_sign;
  logic [XLEN-1:0] req_rs1, req_rs2, mult_mcand, mult_mplier, wb_data;
  logic [TAG_W-1:0] req_tag, wb_tag;
  logic [2*XLEN-1:0] mult_product;

  int checks = 0, failures = 0;
  bit run = 0;

  mult_wb_ctrl #(.XLEN(XLEN), .NUM_STAGE(NUM_STAGE), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .mult_start(mult_start), .mult_sign(mult_sign),
    .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
    .mult_product(mult_product), .mult_done(mult_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .lat_err(lat_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- multiplier stand-in (fixed latency, non-stallable)
  function automatic logic [63:0] prod(input logic [31:0] a, b, input logic [1:0] s);
    logic [63:0] x, y;
    x = s[0] ? {{32{a[31]}}, a} : {32'b0, a};
    y = s[1] ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  logic [NUM_STAGE-1:0] mv;
  logic [63:0] mp [NUM_STAGE];
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) mv <= '0;
    else begin
      mv <= {mv[NUM_STAGE-2:0], mult_start};
      mp[0] <= prod(mult_mcand, mult_mplier, mult_sign);
      for (int i = 1; i < NUM_STAGE; i++) mp[i] <= mp[i-1];
    end
  end
  assign mult_done    = mv[NUM_STAGE-1] | inj;
  assign mult_product = mp[NUM_STAGE-1];

  // ---------------- reference model: RV32M result rules + queues
  function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    case (f)
      2'd0: begin p = sa * sb; return p[31:0]; end
      2'd1: begin p = sa * sb; return p[63:32]; end
      2'd2: begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  function automatic logic [1:0] ref_sign(input logic [1:0] f);
    case (f)
      2'd1: return 2'b11;
      2'd2: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  typedef struct { int due; logic [TAG_W-1:0] tag; logic [31:0] data; } op_t;
  op_t iq[$];   // issued, not yet landed
  op_t fq[$];   // landed, visible at writeback
  int cyc = 0;
  logic exp_lat;

  always @(posedge clock or negedge reset_n) begin : mdl
    bit rd, acc;
    op_t o;
    if (!reset_n) begin
      iq.delete(); fq.delete(); exp_lat <= 1'b0;
    end else begin
`ifdef MULT_WB_LATCHK_EN
      if (inj) exp_lat <= 1'b1;
`endif
      if (flush) begin
        iq.delete(); fq.delete();
      end else begin
        rd  = (fq.size() != 0) && wb_ready;
        acc = req_valid && ((fq.size() + iq.size()) < FIFO_DEPTH);
        if (rd) void'(fq.pop_front());
        if (iq.size() != 0 && iq[0].due == cyc) fq.push_back(iq.pop_front());
        if (acc) begin
          o.due = cyc + NUM_STAGE; o.tag = req_tag;
          o.data = ref_res(req_func, req_rs1, req_rs2);
          iq.push_back(o);
        end
      end
      cyc <= cyc + 1;
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clock) begin
    bit exp_rdy;
    if (run) begin
      exp_rdy = !flush && ((fq.size() + iq.size()) < FIFO_DEPTH);
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("mult_start", 64'(mult_start), 64'(req_valid && exp_rdy));
      chk("mult_sign", 64'(mult_sign), 64'(ref_sign(req_func)));
      chk("mult_mcand", 64'(mult_mcand), 64'(req_rs1));
      chk("mult_mplier", 64'(mult_mplier), 64'(req_rs2));
      chk("wb_valid", 64'(wb_valid), 64'(fq.size() != 0));
      if (fq.size() != 0) begin
        chk("wb_data", 64'(wb_data), 64'(fq[0].data));
        chk("wb_tag", 64'(wb_tag), 64'(fq[0].tag));
      end
      chk("lat_err", 64'(lat_err), 64'(exp_lat));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a, b,
                       input logic [TAG_W-1:0] t);
    req_valid = v; req_func = f; req_rs1 = a; req_rs2 = b; req_tag = t;
  endtask

  initial begin
    int acc;
    reset_n = 1'b0; flush = 1'b0; wb_ready = 1'b0; inj = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, '0);

    // model pinned against hand-computed products
    chk("ref_mul", 64'(ref_res(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h1);
    chk("ref_mulh", 64'(ref_res(2'd1, 32'h80000000, 32'h80000000)), 64'h40000000);
    chk("ref_mulhsu", 64'(ref_res(2'd2, 32'h80000000, 32'hFFFFFFFF)), 64'h80000000);
    chk("ref_mulhu", 64'(ref_res(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);

    step(2);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_wb_data", 64'(wb_data), 64'h0);
    chk("rst_wb_tag", 64'(wb_tag), 64'h0);
    chk("rst_lat_err", 64'(lat_err), 64'h0);
    chk("rst_mult_start", 64'(mult_start), 64'h0);
    reset_n = 1'b1;
    run = 1;
    step();

    // single MUL, latency NUM_STAGE+1
    drive(1'b1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    #1;
    chk("t1_sign", 64'(mult_sign), 64'h0);
    chk("t1_start", 64'(mult_start), 64'h1);
    step();
    req_valid = 1'b0;
    step(3);
    chk("t1_early_valid", 64'(wb_valid), 64'h0);
    step();
    chk("t1_valid", 64'(wb_valid), 64'h1);
    chk("t1_data", 64'(wb_data), 64'h1);
    chk("t1_tag", 64'(wb_tag), 64'h3);
    wb_ready = 1'b1;
    step();

    // back-to-back high-word ops
    drive(1'b1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1); #1;
    chk("t2_sign_mulh", 64'(mult_sign), 64'h3); step();
    drive(1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2); #1;
    chk("t2_sign_mulhsu", 64'(mult_sign), 64'h1); step();
    drive(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3); #1;
    chk("t2_sign_mulhu", 64'(mult_sign), 64'h0); step();
    req_valid = 1'b0;
    step(2);
    chk("t2_d0", 64'(wb_data), 64'h0);        chk("t2_t0", 64'(wb_tag), 64'h1); step();
    chk("t2_d1", 64'(wb_data), 64'hFFFFFFFF); chk("t2_t1", 64'(wb_tag), 64'h2); step();
    chk("t2_d2", 64'(wb_data), 64'hFFFFFFFE); chk("t2_t2", 64'(wb_tag), 64'h3); step();

    // stall: exactly FIFO_DEPTH accepted
    wb_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'($urandom), $urandom, $urandom, 5'(i));
      #1;
      if (req_ready) acc++;
      if (i >= 8) chk("t3_ready_low", 64'(req_ready), 64'h0);
      step();
    end
    chk("t3_accepted", 64'(acc), 64'(FIFO_DEPTH));
    req_valid = 1'b0;
    step(6);
    chk("t3_still_low", 64'(req_ready), 64'h0);
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_valid", 64'(wb_valid), 64'h1);
      chk("t3_drain_tag", 64'(wb_tag), 64'(i));
      if (i == 0) chk("t3_ready_at_read", 64'(req_ready), 64'h0);
      if (i == 1) chk("t3_credit_back", 64'(req_ready), 64'h1);
      step();
    end
    chk("t3_empty", 64'(wb_valid), 64'h0);

    // flush with ops in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, $urandom, $urandom, 5'(20 + i)); step();
    end
    req_valid = 1'b0; step();
    flush = 1'b1; drive(1'b1, 2'd0, 32'h5, 32'h7, 5'd30); #1;
    chk("t4_flush_ready", 64'(req_ready), 64'h0);
    chk("t4_flush_start", 64'(mult_start), 64'h0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_no_stale", 64'(wb_valid), 64'h0); step();
    end
    drive(1'b1, 2'd0, 32'h12345678, 32'h10, 5'd9); step();
    req_valid = 1'b0; step(3);
    chk("t4_post_early", 64'(wb_valid), 64'h0); step();
    chk("t4_post_valid", 64'(wb_valid), 64'h1);
    chk("t4_post_data", 64'(wb_data), 64'h23456780);
    chk("t4_post_tag", 64'(wb_tag), 64'h9);
    step();

    // async reset with 4 buffered and 2 in flight
    wb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'($urandom), $urandom, $urandom, 5'(i)); step();
    end
    req_valid = 1'b0; step(2);
    chk("t5_pre_valid", 64'(wb_valid), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(wb_valid), 64'h0);
    chk("t5_rst_ready", 64'(req_ready), 64'h1);
    #2 reset_n = 1'b1;
    step();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_no_stale", 64'(wb_valid), 64'h0); step();
    end

    // randomized traffic with shifting backpressure and occasional flush
    for (int ph = 0; ph < 10; ph++) begin
      int rp;
      rp = $urandom_range(0, 4);
      for (int i = 0; i < 200; i++) begin
        drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom, 5'($urandom));
        wb_ready = ($urandom_range(0, 4) < rp);
        flush = ($urandom_range(0, 59) == 0);
        step();
      end
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, '0);
    flush = 1'b0; wb_ready = 1'b1;
    step(16);
    chk("rnd_drained", 64'(wb_valid), 64'h0);

`ifdef MULT_WB_LATCHK_EN
    inj = 1'b1; step(); inj = 1'b0;
    chk("t6_lat_err", 64'(lat_err), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_lat_held", 64'(lat_err), 64'h1);
      chk("t6_no_write", 64'(wb_valid), 64'h0);
    end
`endif

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
